// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative RV32M multiply/divide unit: funct3 codes,
// FSM state encoding and iteration counter width.
package muldiv_pkg;

  localparam int CNT_W = 6;

  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } state_t;

endpackage

// File: rtl/muldiv_signfix.sv
// Final sign correction and word selection for multiply and divide results.
// The low accumulator word doubles as the quotient, so one negator serves both paths.
module muldiv_signfix
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic [2:0]         op,
  input  logic [2*WIDTH-1:0] prod,
  input  logic [WIDTH-1:0]   rem,
  input  logic               neg_q,
  input  logic               neg_r,
  output logic [WIDTH-1:0]   res
);

  logic [2*WIDTH-1:0] prod_fix;
  logic [WIDTH-1:0]   rem_fix;

  always_comb begin
    prod_fix = neg_q ? (~prod + 1'b1) : prod;
    rem_fix  = neg_r ? (~rem + 1'b1) : rem;
    res      = '0;
    case (op)
      F3_MUL, F3_DIV, F3_DIVU:      res = prod_fix[WIDTH-1:0];
      F3_MULH, F3_MULHSU, F3_MULHU: res = prod_fix[2*WIDTH-1:WIDTH];
      F3_REM, F3_REMU:              res = rem_fix;
      default:                      res = '0;
    endcase
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: shift-add multiply or restoring divide, one bit per cycle.
// Define MULDIV_DIV_EN to build the divide datapath; without it divide ops return 0 in one cycle.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             start,
  input  logic [2:0]       funct3,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] result
);

  localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [2:0]         op_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [WIDTH-1:0]   opnd_q;
  logic [WIDTH-1:0]   result_q;
  logic               neg_q_q, neg_r_q, busy_q, done_q;

  logic               a_signed, b_signed, sign_a, sign_b;
  logic [WIDTH-1:0]   mag_a, mag_b;
  logic               short_path;
  logic [WIDTH-1:0]   short_res;
  logic [WIDTH:0]     mul_sum;
  logic [2*WIDTH-1:0] mul_next;
  logic [WIDTH-1:0]   rem_word;
  logic [WIDTH-1:0]   fix_res;

  always_comb begin
    a_signed = (funct3 == F3_MULH) || (funct3 == F3_MULHSU) ||
               (funct3 == F3_DIV)  || (funct3 == F3_REM);
    b_signed = (funct3 == F3_MULH) || (funct3 == F3_DIV) || (funct3 == F3_REM);
    sign_a   = a_signed & a[WIDTH-1];
    sign_b   = b_signed & b[WIDTH-1];
    mag_a    = sign_a ? (~a + 1'b1) : a;
    mag_b    = sign_b ? (~b + 1'b1) : b;
  end

  // Multiplier lives in the low half and shifts out as the product shifts in.
  assign mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[WIDTH-1:1]};

`ifdef MULDIV_DIV_EN
  logic [WIDTH-1:0] rem_q;
  logic [WIDTH:0]   div_shift, div_diff;
  logic             div_zero, div_ovf;

  assign div_shift  = {rem_q, acc_q[WIDTH-1]};
  assign div_diff   = div_shift - {1'b0, opnd_q};
  assign div_zero   = (b == '0);
  assign div_ovf    = ~funct3[0] && (a == MIN_NEG) && (b == '1);
  assign short_path = funct3[2] && (div_zero || div_ovf);
  assign short_res  = funct3[1] ? (div_zero ? a : '0) : (div_zero ? '1 : MIN_NEG);
  assign rem_word   = rem_q;
`else
  assign short_path = funct3[2];
  assign short_res  = '0;
  assign rem_word   = '0;
`endif

  muldiv_signfix #(.WIDTH(WIDTH)) u_signfix (
    .op    (op_q),
    .prod  (acc_q),
    .rem   (rem_word),
    .neg_q (neg_q_q),
    .neg_r (neg_r_q),
    .res   (fix_res)
  );

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      acc_q    <= '0;
      opnd_q   <= '0;
      result_q <= '0;
      neg_q_q  <= 1'b0;
      neg_r_q  <= 1'b0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef MULDIV_DIV_EN
      rem_q    <= '0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          done_q <= 1'b0;
          if (start) begin
            op_q    <= funct3;
            neg_q_q <= sign_a ^ sign_b;
            neg_r_q <= sign_a;
            cnt_q   <= CNT_W'(WIDTH - 1);
            busy_q  <= 1'b1;
            acc_q   <= {{WIDTH{1'b0}}, (funct3[2] ? mag_a : mag_b)};
            opnd_q  <= funct3[2] ? mag_b : mag_a;
`ifdef MULDIV_DIV_EN
            rem_q   <= '0;
`endif
            if (short_path) begin
              result_q <= short_res;
              done_q   <= 1'b1;
              state_q  <= DONE;
            end else begin
              state_q  <= CALC;
            end
          end
        end
        CALC: begin
`ifdef MULDIV_DIV_EN
          if (op_q[2]) begin
            acc_q[WIDTH-1:0] <= {acc_q[WIDTH-2:0], ~div_diff[WIDTH]};
            rem_q <= div_diff[WIDTH] ? div_shift[WIDTH-1:0] : div_diff[WIDTH-1:0];
          end else begin
            acc_q <= mul_next;
          end
`else
          acc_q <= mul_next;
`endif
          cnt_q <= cnt_q - CNT_W'(1);
          if (cnt_q == '0) state_q <= FIX;
        end
        FIX: begin
          result_q <= fix_res;
          done_q   <= 1'b1;
          state_q  <= DONE;
        end
        DONE: begin
          done_q  <= 1'b0;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy   = busy_q;
  assign done   = done_q;
  assign result = result_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Directed bench for muldiv_unit: arithmetic reference model, per-cycle result monitor,
// latency/busy checks per operation, ignored-start and mid-operation reset cases.
module tb_muldiv_unit;

  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic        start = 1'b0;
  logic [2:0]  funct3 = 3'b000;
  logic [31:0] opa = '0;
  logic [31:0] opb = '0;
  logic        busy, done;
  logic [31:0] result;

  int vectors = 0;
  int miscompares = 0;
  logic [31:0] exp_res = '0;
  logic [31:0] held_res = '0;

  always #5 clk = ~clk;

  muldiv_unit #(.WIDTH(32)) dut (
    .clk    (clk),
    .rstn   (rstn),
    .start  (start),
    .funct3 (funct3),
    .a      (opa),
    .b      (opb),
    .busy   (busy),
    .done   (done),
    .result (result)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference results from plain integer arithmetic.
  function automatic logic [31:0] model(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
    longint sp;
    logic [63:0] up;
    int sx, sy, q;
    sx = x;
    sy = y;
    case (op)
      3'd0: begin up = {32'b0, x} * {32'b0, y}; return up[31:0]; end
      3'd1: begin sp = longint'($signed(x)) * longint'($signed(y)); return sp[63:32]; end
      3'd2: begin sp = longint'($signed(x)) * longint'({32'b0, y}); return sp[63:32]; end
      3'd3: begin up = {32'b0, x} * {32'b0, y}; return up[63:32]; end
      default: ;
    endcase
`ifdef MULDIV_DIV_EN
    case (op)
      3'd4: begin
        if (y == 0) return 32'hFFFF_FFFF;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h8000_0000;
        q = sx / sy; return q;
      end
      3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
      3'd6: begin
        if (y == 0) return x;
        if (x == 32'h8000_0000 && y == 32'hFFFF_FFFF) return 32'h0;
        q = sx % sy; return q;
      end
      default: return (y == 0) ? x : x % y;
    endcase
`else
    return 32'h0;
`endif
  endfunction

  function automatic int model_lat(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y);
`ifdef MULDIV_DIV_EN
    if (op[2] && (y == 0 || (!op[0] && x == 32'h8000_0000 && y == 32'hFFFF_FFFF))) return 1;
    return 34;
`else
    return op[2] ? 1 : 34;
`endif
  endfunction

  // Hand-computed divide literals collapse to 0 when the divider is not built.
  function automatic logic [31:0] dl(input logic [31:0] v);
`ifdef MULDIV_DIV_EN
    return v;
`else
    return 32'h0;
`endif
  endfunction

  // Every cycle out of reset: result must equal the new value while done, else the held value.
  always @(negedge clk) begin
    if (rstn) begin
      chk("result_cycle", result, done ? exp_res : held_res);
      if (done) held_res = exp_res;
    end
  end

  task automatic run(input logic [2:0] op, input logic [31:0] x, input logic [31:0] y,
                     input logic [31:0] lit, input bit has_lit, input int inj_start, input int inj_rst);
    int edges, busy_cyc, lat;
    lat = model_lat(op, x, y);
    exp_res = model(op, x, y);
    @(negedge clk);
    funct3 = op; opa = x; opb = y; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; funct3 = ~op; opa = ~x; opb = y ^ 32'h5A5A_5A5A;
    edges = 1;
    busy_cyc = busy ? 1 : 0;
    while (!done && edges < 100) begin
      if (edges == inj_start) begin
        start = 1'b1; funct3 = 3'b011; opa = 32'hFFFF_FFFF; opb = 32'hFFFF_FFFF;
      end
      if (edges == inj_rst) begin
        rstn = 1'b0;
        held_res = '0;
        #1;
        chk("rst_busy", {31'b0, busy}, 32'd0);
        chk("rst_done", {31'b0, done}, 32'd0);
        chk("rst_result", result, 32'd0);
        @(negedge clk); #1;
        rstn = 1'b1;
        $display("op=%0d a=%h b=%h aborted by reset at cycle %0d", op, x, y, edges);
        return;
      end
      @(posedge clk); #1;
      start = 1'b0;
      edges++;
      if (busy) busy_cyc++;
    end
    chk("latency", edges, lat);
    chk("busy_cycles", busy_cyc, lat);
    if (has_lit) chk("literal", result, lit);
    $display("op=%0d a=%h b=%h result=%h latency=%0d", op, x, y, result, edges);
    @(posedge clk); #1;
    chk("done_pulse", {31'b0, done}, 32'd0);
    chk("busy_after", {31'b0, busy}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    chk("reset_done", {31'b0, done}, 32'd0);
    chk("reset_result", result, 32'd0);
    rstn = 1'b1;

    run(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 0, 0);
    run(3'd1, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1, 0, 0);
    run(3'd3, 32'h8000_0000,  32'h8000_0000, 32'h4000_0000, 1, 0, 0);
    run(3'd2, 32'hFFFF_FFFF,  32'd2,         32'hFFFF_FFFF, 1, 0, 0);
    run(3'd1, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'h0,         1, 0, 0);
    run(3'd3, 32'hFFFF_FFFF,  32'hFFFF_FFFF, 32'hFFFF_FFFE, 1, 0, 0);
    run(3'd0, 32'h1234_5678,  32'h9ABC_DEF0, 32'h0,         0, 0, 0);
    run(3'd5, 32'd100,        32'd7,         dl(32'd14),    1, 0, 0);
    run(3'd7, 32'd100,        32'd7,         dl(32'd2),     1, 0, 0);
    run(3'd4, 32'hFFFF_FFF9,  32'd2,         dl(32'hFFFF_FFFD), 1, 0, 0);
    run(3'd6, 32'hFFFF_FFF9,  32'd2,         dl(32'hFFFF_FFFF), 1, 0, 0);
    run(3'd4, 32'hFFFF_FFF9,  32'hFFFF_FFFE, dl(32'd3),     1, 0, 0);
    run(3'd6, 32'hFFFF_FFF9,  32'hFFFF_FFFE, dl(32'hFFFF_FFFF), 1, 0, 0);
    run(3'd4, 32'd5,          32'd0,         dl(32'hFFFF_FFFF), 1, 0, 0);
    run(3'd6, 32'd5,          32'd0,         dl(32'd5),     1, 0, 0);
    run(3'd5, 32'd7,          32'd0,         dl(32'hFFFF_FFFF), 1, 0, 0);
    run(3'd7, 32'd7,          32'd0,         dl(32'd7),     1, 0, 0);
    run(3'd4, 32'h8000_0000,  32'hFFFF_FFFF, dl(32'h8000_0000), 1, 0, 0);
    run(3'd6, 32'h8000_0000,  32'hFFFF_FFFF, dl(32'h0),     1, 0, 0);
    run(3'd0, 32'd6,          32'd7,         32'd42,        1, 0, 0);

    // A second start during a multiply must be ignored.
    run(3'd0, 32'd7,          32'hFFFF_FFFD, 32'hFFFF_FFEB, 1, 10, 0);

    // Reset in the middle of a long operation, then a fresh operation.
`ifdef MULDIV_DIV_EN
    run(3'd4, 32'h1234_5678,  32'h0000_0123, 32'h0,         0, 0, 20);
`else
    run(3'd0, 32'h1234_5678,  32'h0000_0123, 32'h0,         0, 0, 20);
`endif
    run(3'd5, 32'd100,        32'd7,         dl(32'd14),    1, 0, 0);
    run(3'd0, 32'd6,          32'd7,         32'd42,        1, 0, 0);

    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
